// File: rtl/lsu_axi_master_pkg.sv
// Shared AXI constants and the state encoding of the load/store-to-AXI bridge.
package lsu_axi_master_pkg;

    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [3:0] CACHE_MODIFIABLE = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT     = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RSP
    } state_t;

    // Requests wider than the data bus are narrowed to a full-bus transfer.
    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4 master/slave bundle between the bridge and the downstream slave.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where both valid and ready are high; once raised, valid and its payload stay
// stable until that transfer, and valid never depends on ready.
interface lsu_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/lsu_axi_master_stdreg.sv
// Plain enabled register with synchronous active-low reset.
module lsu_axi_master_stdreg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding bridge: each core load/store becomes one single-beat AXI4
// transaction, and its result comes back on a registered response port.
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2:0]            i_req_size,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [STRB_WIDTH-1:0] i_req_wmask,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,

    lsu_axi_master_if.master      m_axi,

    output state_t                o_state
);

    localparam logic [2:0]          MAX_SIZE = 3'($clog2(STRB_WIDTH));
    localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(AXI_ID);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wmask_q, wmask_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rdata_en;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Next-state and next-output decode; every register holds unless a state says otherwise.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_d = req_ready_q;
        rsp_err_d   = rsp_err_q;
        rdata_en    = 1'b0;
        rdata_d     = '0;

        case (state_q)
            S_IDLE: begin
                // req_ready is cleared by reset, so the first idle cycle only re-arms it.
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (i_req_valid) begin
                    req_ready_d = 1'b0;
                    addr_d      = i_req_addr;
                    size_d      = clamp_size(i_req_size, MAX_SIZE);
                    wdata_d     = i_req_wdata;
                    wmask_d     = i_req_wmask;
                    if (i_req_wen) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently, in any order.
                if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = (m_axi.bresp != RESP_OKAY) | (m_axi.bid != ID_VAL);
                    rdata_en    = 1'b1;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi.rvalid) begin
                    rready_d    = 1'b0;
                    rdata_en    = 1'b1;
                    rdata_d     = m_axi.rdata;
                    rsp_err_d   = (m_axi.rresp != RESP_OKAY) | !m_axi.rlast | (m_axi.rid != ID_VAL);
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                // Returning to IDLE with req_ready set keeps accept out of the handshake cycle.
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    lsu_axi_master_stdreg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL ('0)
    ) u_rdata_reg (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (rdata_en),
        .d     (rdata_d),
        .q     (rdata_q)
    );

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_state     = state_q;

    assign m_axi.awid    = ID_VAL;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = CACHE_MODIFIABLE;
    assign m_axi.awprot  = PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wmask_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = wvalid_q;

    assign m_axi.bready  = bready_q;

    assign m_axi.arid    = ID_VAL;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = CACHE_MODIFIABLE;
    assign m_axi.arprot  = PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: behavioural AXI slave with a small memory,
// vector table plus hand-written corner sequences, response scoreboard.
module tb_lsu_axi_master;
    import lsu_axi_master_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
    localparam int IW = 4;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_wen;
    logic [AW-1:0] i_req_addr;
    logic [2:0]    i_req_size;
    logic [DW-1:0] i_req_wdata;
    logic [SW-1:0] i_req_wmask;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    state_t        o_state;

    lsu_axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    lsu_axi_master #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STRB_WIDTH (SW),
        .ID_WIDTH   (IW),
        .AXI_ID     (0)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wen   (i_req_wen),
        .i_req_addr  (i_req_addr),
        .i_req_size  (i_req_size),
        .i_req_wdata (i_req_wdata),
        .i_req_wmask (i_req_wmask),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .m_axi       (bus),
        .o_state     (o_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural AXI slave ----------------
    int          aw_delay, w_delay, ar_delay, r_lat;
    int          inj;  // 0 none, 1 rresp SLVERR, 2 rlast=0, 3 bad rid, 4 bresp SLVERR, 5 bad bid
    logic [31:0] mem [0:63];
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [2:0]  cap_arsize, cap_awsize;
    logic [3:0]  cap_wstrb;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt;
    logic        ar_done, aw_done, w_done;
    logic        ar_armed, r_armed, aw_armed, w_armed, b_armed;

    task automatic slave_clear();
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.rlast = 1'b0;   bus.rid = '0;
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0;  bus.bresp = 2'b00; bus.bid = '0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
        ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0;
        ar_armed = 1'b0; r_armed = 1'b0; aw_armed = 1'b0; w_armed = 1'b0; b_armed = 1'b0;
    endtask

    task automatic slave_read_step();
        if (r_armed) bus.rvalid = 1'b0;
        if (ar_armed) begin
            bus.arready = 1'b0; ar_done = 1'b1; ar_cnt = 0; r_cnt = 0;
        end else if (bus.arvalid && !ar_done && !bus.arready) begin
            if (ar_cnt >= ar_delay) begin
                bus.arready = 1'b1; cap_araddr = bus.araddr; cap_arsize = bus.arsize;
            end else ar_cnt++;
        end
        if (ar_done && !bus.rvalid) begin
            if (r_cnt >= r_lat) begin
                bus.rvalid = 1'b1;
                bus.rdata  = mem[cap_araddr[7:2]];
                bus.rresp  = (inj == 1) ? 2'b10 : 2'b00;
                bus.rlast  = (inj != 2);
                bus.rid    = (inj == 3) ? 4'd5 : 4'd0;
                ar_done    = 1'b0;
            end else r_cnt++;
        end
        ar_armed = bus.arready && bus.arvalid;
        r_armed  = bus.rvalid && bus.rready;
    endtask

    task automatic slave_write_step();
        if (b_armed) bus.bvalid = 1'b0;
        if (aw_armed) begin
            bus.awready = 1'b0; aw_done = 1'b1; aw_cnt = 0;
        end else if (bus.awvalid && !aw_done && !bus.awready) begin
            if (aw_cnt >= aw_delay) begin
                bus.awready = 1'b1; cap_awaddr = bus.awaddr; cap_awsize = bus.awsize;
            end else aw_cnt++;
        end
        if (w_armed) begin
            bus.wready = 1'b0; w_done = 1'b1; w_cnt = 0;
        end else if (bus.wvalid && !w_done && !bus.wready) begin
            if (w_cnt >= w_delay) begin
                bus.wready = 1'b1; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb;
            end else w_cnt++;
        end
        if (aw_done && w_done && !bus.bvalid) begin
            for (int i = 0; i < 4; i++)
                if (cap_wstrb[i]) mem[cap_awaddr[7:2]][8*i +: 8] = cap_wdata[8*i +: 8];
            bus.bvalid = 1'b1;
            bus.bresp  = (inj == 4) ? 2'b10 : 2'b00;
            bus.bid    = (inj == 5) ? 4'd3 : 4'd0;
            aw_done = 1'b0; w_done = 1'b0;
        end
        aw_armed = bus.awready && bus.awvalid;
        w_armed  = bus.wready && bus.wvalid;
        b_armed  = bus.bvalid && bus.bready;
    endtask

    initial begin
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_lat = 0; inj = 0;
        slave_clear();
        forever begin
            @(negedge i_clk); #1;
            if (!i_rst_n) slave_clear();
            else begin
                slave_read_step();
                slave_write_step();
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW:0] exp_q[$];  // {err, rdata}

    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge i_clk); #1;
            if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", o_rsp_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, e[DW-1:0]);
                    check("rsp_err", o_rsp_err, e[DW]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata, input logic [3:0] wmask, input logic [DW:0] exp);
        i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr; i_req_size = size;
        i_req_wdata = wdata; i_req_wmask = wmask;
        exp_q.push_back(exp);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, input logic [3:0] wmask, input logic [DW:0] exp);
        int waited = 0;
        drive_req(wen, addr, size, wdata, wmask, exp);
        while (!o_req_ready && waited < 50) begin @(negedge i_clk); waited++; end
        check("req_accept", o_req_ready, 1'b1);
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (!(o_req_ready && exp_q.size() == 0) && waited < 100) begin
            @(negedge i_clk); waited++;
        end
        check("idle_reached", o_req_ready, 1'b1);
        check("rsp_drained", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          inj;
        logic [2:0]  exp_size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        int aw_cycles, w_cycles, waited;
        logic early_b, seen_b;

        vecs[0]  = '{1'b0, 32'h10, 3'd2, 32'h0,        4'h0, 0, 3'd2, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h20, 3'd2, 32'h12345678, 4'h3, 0, 3'd2, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h20, 3'd2, 32'h0,        4'h0, 0, 3'd2, 32'hAAAA5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h30, 3'd7, 32'hCAFEF00D, 4'hF, 0, 3'd2, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h30, 3'd5, 32'h0,        4'h0, 0, 3'd2, 32'hCAFEF00D, 1'b0};
        vecs[5]  = '{1'b0, 32'h10, 3'd2, 32'h0,        4'h0, 1, 3'd2, 32'hDEADBEEF, 1'b1};
        vecs[6]  = '{1'b0, 32'h10, 3'd2, 32'h0,        4'h0, 2, 3'd2, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b0, 32'h10, 3'd2, 32'h0,        4'h0, 3, 3'd2, 32'hDEADBEEF, 1'b1};
        vecs[8]  = '{1'b1, 32'h30, 3'd2, 32'h11112222, 4'hC, 4, 3'd2, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h38, 3'd1, 32'h0000BEEF, 4'h3, 5, 3'd1, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h12, 3'd0, 32'h0,        4'h0, 0, 3'd0, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{1'b0, 32'h30, 3'd2, 32'h0,        4'h0, 0, 3'd2, 32'h1111F00D, 1'b0};
        vecs[12] = '{1'b0, 32'h38, 3'd2, 32'h0,        4'h0, 0, 3'd2, 32'h0000BEEF, 1'b0};

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'hAAAABBBB;

        // ---- reset ----
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0;
        i_req_size = '0; i_req_wdata = '0; i_req_wmask = '0; i_rsp_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_req_ready", o_req_ready, 1'b0);
        check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, o_rsp_valid}, 6'b0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        check("rst_rsp_err", o_rsp_err, 1'b0);
        check("rst_state", o_state, S_IDLE);
        check("const_fields", {bus.awlen, bus.arlen, bus.awburst, bus.arburst, bus.awlock, bus.arlock,
                               bus.awcache, bus.arcache, bus.awprot, bus.arprot, bus.wlast, bus.awid, bus.arid},
              {8'd0, 8'd0, 2'b01, 2'b01, 1'b0, 1'b0, 4'b0011, 4'b0011, 3'b000, 3'b000, 1'b1, 4'd0, 4'd0});
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("req_ready_after_reset", o_req_ready, 1'b1);

        // ---- load latency with zero-wait slave ----
        drive_req(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("lat_arvalid", bus.arvalid, 1'b1);
        check("lat_araddr", bus.araddr, 32'h10);
        check("lat_arsize", bus.arsize, 3'd2);
        check("lat_req_ready_low", o_req_ready, 1'b0);
        @(negedge i_clk);
        check("lat_ar_done", {bus.arvalid, bus.rready}, 2'b01);
        @(negedge i_clk);
        check("lat_rsp_valid", o_rsp_valid, 1'b1);
        wait_idle();

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
            ar_delay = $urandom_range(0, 2); r_lat   = $urandom_range(0, 3);
            inj = vecs[i].inj;
            send_req(vecs[i].wen, vecs[i].addr, vecs[i].size, vecs[i].wdata, vecs[i].wmask,
                     {vecs[i].exp_err, vecs[i].exp_rdata});
            wait_idle();
            if (vecs[i].wen) begin
                check("vec_awaddr", cap_awaddr, vecs[i].addr);
                check("vec_awsize", cap_awsize, vecs[i].exp_size);
                check("vec_wdata", cap_wdata, vecs[i].wdata);
                check("vec_wstrb", cap_wstrb, vecs[i].wmask);
            end else begin
                check("vec_araddr", cap_araddr, vecs[i].addr);
                check("vec_arsize", cap_arsize, vecs[i].exp_size);
            end
        end
        inj = 0;

        // ---- AW stalled three cycles, W immediate ----
        aw_delay = 3; w_delay = 0;
        aw_cycles = 0; w_cycles = 0; early_b = 1'b0; seen_b = 1'b0;
        drive_req(1'b1, 32'h34, 3'd2, 32'hA5A5A5A5, 4'hF, {1'b0, 32'h0});
        @(negedge i_clk);
        i_req_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.awvalid) aw_cycles++;
            if (bus.wvalid) w_cycles++;
            if (bus.bready && (bus.awvalid || bus.wvalid)) early_b = 1'b1;
            if (bus.bready) seen_b = 1'b1;
            @(negedge i_clk);
        end
        check("stall_aw_cycles", aw_cycles, 4);
        check("stall_w_cycles", w_cycles, 1);
        check("stall_no_early_bready", early_b, 1'b0);
        check("stall_bready_seen", seen_b, 1'b1);
        wait_idle();
        aw_delay = 0;
        send_req(1'b0, 32'h34, 3'd2, 32'h0, 4'h0, {1'b0, 32'hA5A5A5A5});
        wait_idle();

        // ---- response back-pressure ----
        i_rsp_ready = 1'b0;
        send_req(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        waited = 0;
        while (!o_rsp_valid && waited < 50) begin @(negedge i_clk); waited++; end
        check("hold_rsp_seen", o_rsp_valid, 1'b1);
        drive_req(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, {1'b0, 32'hAAAA5678});
        for (int k = 0; k < 5; k++) begin
            check("hold_rsp_valid", o_rsp_valid, 1'b1);
            check("hold_rsp_rdata", o_rsp_rdata, 32'hDEADBEEF);
            check("hold_req_ready", o_req_ready, 1'b0);
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        check("hs_rsp_valid_drop", o_rsp_valid, 1'b0);
        check("hs_req_ready_rise", o_req_ready, 1'b1);
        check("hs_no_same_cycle_accept", bus.arvalid, 1'b0);
        @(negedge i_clk);
        check("hs_next_accept", bus.arvalid, 1'b1);
        i_req_valid = 1'b0;
        wait_idle();

        // ---- reset during RD_DATA ----
        r_lat = 10;
        send_req(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF});
        waited = 0;
        while (!bus.rready && waited < 20) begin @(negedge i_clk); waited++; end
        check("mid_rst_in_rd_data", o_state, S_RD_DATA);
        i_rst_n = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        check("mid_rst_outputs", {bus.arvalid, bus.rready, o_rsp_valid, o_req_ready}, 4'b0);
        check("mid_rst_state", o_state, S_IDLE);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("mid_rst_req_ready", o_req_ready, 1'b1);
        r_lat = 0;
        send_req(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, {1'b0, 32'hAAAA5678});
        wait_idle();

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Single-outstanding bridge from the core's simple load/store request port to an AXI4 master port.
- Sits directly upstream of axi_sram and drives its s_axi_* slave channels.
- Each request becomes exactly one single-beat AXI transaction: AR/R for loads, AW+W/B for stores.
- The response, with read data and an error flag, returns on a valid/ready port.

Parameters:
- DATA_WIDTH, 32, AXI and request data width.
- ADDR_WIDTH, 32, AXI and request address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant value driven on awid and arid.

Ports:
- i_clk input 1: clock; all state changes on its rising edge.
- i_rst_n input 1: reset; synchronous, active-low.
- i_req_valid input 1: request valid.
- o_req_ready output 1: request ready; high only in IDLE.
- i_req_wen input 1: 1 = store, 0 = load.
- i_req_addr input ADDR_WIDTH: byte address.
- i_req_size input 3: AXI size encoding; 0..log2(STRB_WIDTH).
- i_req_wdata input DATA_WIDTH: store data, already lane-aligned.
- i_req_wmask input STRB_WIDTH: store byte strobes, already lane-aligned.
- o_rsp_valid output 1: response valid.
- i_rsp_ready input 1: response accepted.
- o_rsp_rdata output DATA_WIDTH: load data; 0 for stores.
- o_rsp_err output 1: 1 if the AXI response was not OKAY, or on a protocol error.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid} output / m_axi_awready input: AW channel, standard AXI4 widths.
- m_axi_w{data,strb,last,valid} output / m_axi_wready input: W channel.
- m_axi_b{id,resp,valid} input / m_axi_bready output: B channel.
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid} output / m_axi_arready input: AR channel.
- m_axi_r{id,data,resp,last,valid} input / m_axi_rready output: R channel.

Behaviour:
- All outputs are registered.
- Constant fields:
  - awlen = arlen = 0, awburst = arburst = 2'b01.
  - lock = 0, cache = 4'b0011, prot = 3'b000.
  - wlast = 1, aw/arid = AXI_ID.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- Reset (i_rst_n = 0 at a clock edge):
  - state goes to IDLE.
  - All valids and readies (awvalid, wvalid, arvalid, bready, rready, o_rsp_valid) are 0.
  - o_req_ready = 1 from the first cycle after reset is released.
  - o_rsp_rdata = 0, o_rsp_err = 0.
  - Reset mid-transaction abandons the transaction immediately. No AXI completion is awaited; the downstream slave is reset by the same reset.
- IDLE: o_req_ready = 1. On i_req_valid & o_req_ready:
  - Latch addr, size, wdata, wmask.
  - o_req_ready goes low the next cycle.
  - Store: go to WR_REQ with awvalid = 1 and wvalid = 1 in the next cycle.
  - Load: go to RD_ADDR with arvalid = 1 in the next cycle.
- WR_REQ:
  - awvalid drops the cycle after awvalid & awready; wvalid drops the cycle after wvalid & wready. The two channels are handled independently and may complete in either order or in the same cycle.
  - Once both have completed, go to WR_RESP with bready = 1.
  - A valid must never drop before its handshake.
- WR_RESP:
  - On bvalid & bready: bready drops; o_rsp_err = (bresp != 0) | (bid != AXI_ID); o_rsp_rdata = 0; go to RSP.
- RD_ADDR:
  - On arvalid & arready: arvalid drops and rready rises next cycle; go to RD_DATA.
- RD_DATA:
  - On rvalid & rready: capture rdata; o_rsp_err = (rresp != 0) | !rlast | (rid != AXI_ID); rready drops; go to RSP.
- RSP:
  - o_rsp_valid = 1, held stable until i_rsp_ready.
  - On handshake: o_rsp_valid drops and o_req_ready rises next cycle (IDLE).
  - No new request is accepted in the same cycle as the response handshake.
- Latency: with zero-wait ready signals, a load completes in request-accept + 1 cycle (AR) + slave latency + 1 cycle (RSP registered).
- Sizes above log2(STRB_WIDTH) are forwarded clamped to log2(STRB_WIDTH).
- Exactly one transaction is outstanding at any time; there is no pipelining.

Decomposition:
- Shared package axi_pkg:
  - AXI burst/resp/cache constants: BURST_INCR, RESP_OKAY, CACHE_MODIFIABLE.
  - The state enum encoding for this block.
- No sub-module is needed; stdreg is used for the captured rdata register.

Test Plan:
- Load to axi_sram at 0x0000_0010, where memory holds 0xDEADBEEF: arvalid 1 cycle after accept, araddr=0x10, arsize=2, arlen=0; o_rsp_rdata=0xDEADBEEF, o_rsp_err=0.
- Store 0x12345678 with wmask 4'b0011 to 0x20: awaddr=0x20 and wstrb=0011; a subsequent load from 0x20 returns only the low half updated; o_rsp_err=0.
- awready held low 3 cycles while wready is immediate: wvalid drops after 1 cycle, awvalid held stable until awready; bready asserts only after both handshakes.
- Slave returns rresp=2'b10 (SLVERR), and in a second case rlast=0: o_rsp_err=1 in both.
- i_rsp_ready held low 5 cycles: o_rsp_valid and o_rsp_rdata stay stable, o_req_ready stays 0; a new request is accepted only after the response handshake.
- i_rst_n pulsed low during RD_DATA: next cycle arvalid=rready=o_rsp_valid=0 and o_req_ready=0; o_req_ready=1 the cycle after release; a following load completes correctly.
